// File: rtl/fcvt_share_arbiter.sv
// Round-robin arbiter sharing one float32 -> int32 converter across NUM_REQ requesters.
// Optional macro FCVT_EXC_FLAGS_EN adds the resp_nv / resp_nx exception flag outputs.
module fcvt_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_op,
    input  logic [2*NUM_REQ-1:0]  req_rmode,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_res,
`ifdef FCVT_EXC_FLAGS_EN
    output logic                  resp_nv,
    output logic                  resp_nx,
`endif
    output logic                  busy
);
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    logic [31:0] op_arr    [NUM_REQ];
    logic [1:0]  rmode_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi]    = req_op[32*gi +: 32];
            assign rmode_arr[gi] = req_rmode[2*gi +: 2];
        end
    endgenerate

    logic            valid_a_reg;
    logic [31:0]     op_a_reg;
    logic [1:0]      rmode_a_reg;
    logic [ID_W-1:0] id_a_reg;
    logic            valid_b_reg;
    logic [31:0]     res_b_reg;
    logic [ID_W-1:0] id_b_reg;
    logic [ID_W-1:0] ptr_reg;
    logic [ID_W-1:0] ptr_next;

    logic            adv_a;
    logic            adv_b;
    logic            grant_valid;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   scan_idx;
    logic            take_a;

    assign adv_b  = !valid_b_reg || resp_ready;
    assign adv_a  = !valid_a_reg || adv_b;
    assign take_a = adv_a && grant_valid && !reset;

    // Scan requesters starting at the round-robin pointer, wrapping modulo NUM_REQ.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (!grant_valid && req_valid[scan_idx[ID_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (take_a) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign ptr_next = (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);

    // Conversion datapath between stage A and stage B.
    logic        cv_sign;
    logic [7:0]  exp_b;
    logic [23:0] mant;
    logic [4:0]  sh_amt;
    logic [2:0]  sl_amt;
    logic [47:0] wide;
    logic [23:0] int_part;
    logic        rnd;
    logic        stk;
    logic        inc;
    logic [31:0] mag;
    logic        nv_c;
    logic [31:0] res_c;

    always_comb begin
        cv_sign  = op_a_reg[31];
        exp_b    = op_a_reg[30:23];
        mant     = {|exp_b, op_a_reg[22:0]};
        sh_amt   = 5'(8'd150 - exp_b);
        sl_amt   = 3'(exp_b - 8'd150);
        wide     = {mant, 24'd0} >> sh_amt;
        int_part = wide[47:24];
        rnd      = wide[23];
        stk      = |wide[22:0];
        nv_c     = (exp_b >= 8'd158);
        // Below 0.5 the whole mantissa is sticky; nothing reaches the round bit.
        if (exp_b < 8'd126) begin
            int_part = '0;
            rnd      = 1'b0;
            stk      = |mant;
        end
        inc = 1'b0;
        case (rmode_a_reg)
            2'd0:    inc = rnd && (stk || int_part[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = !cv_sign && (rnd || stk);
            default: inc = cv_sign && (rnd || stk);
        endcase
        if (exp_b >= 8'd150) begin
            mag = {8'd0, mant} << sl_amt;
        end else begin
            mag = {8'd0, int_part} + {31'd0, inc};
        end
        if (nv_c) begin
            res_c = 32'h8000_0000;
        end else if (cv_sign) begin
            res_c = ~mag + 32'd1;
        end else begin
            res_c = mag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_a_reg <= 1'b0;
            op_a_reg    <= '0;
            rmode_a_reg <= '0;
            id_a_reg    <= '0;
            valid_b_reg <= 1'b0;
            res_b_reg   <= '0;
            id_b_reg    <= '0;
            ptr_reg     <= '0;
        end else begin
            if (adv_a) begin
                valid_a_reg <= grant_valid;
                if (grant_valid) begin
                    op_a_reg    <= op_arr[grant_idx];
                    rmode_a_reg <= rmode_arr[grant_idx];
                    id_a_reg    <= grant_idx;
                    ptr_reg     <= ptr_next;
                end
            end
            if (adv_b) begin
                valid_b_reg <= valid_a_reg;
                if (valid_a_reg) begin
                    res_b_reg <= res_c;
                    id_b_reg  <= id_a_reg;
                end
            end
        end
    end

`ifdef FCVT_EXC_FLAGS_EN
    logic nv_b_reg;
    logic nx_b_reg;
    logic nx_c;

    // Inexact whenever any discarded fraction bit is set on a finite in-range operand.
    assign nx_c = !nv_c && (exp_b < 8'd150) && (rnd || stk);

    always_ff @(posedge clock) begin
        if (reset) begin
            nv_b_reg <= 1'b0;
            nx_b_reg <= 1'b0;
        end else if (adv_b && valid_a_reg) begin
            nv_b_reg <= nv_c;
            nx_b_reg <= nx_c;
        end
    end

    assign resp_nv = nv_b_reg;
    assign resp_nx = nx_b_reg;
`endif

    assign resp_valid = valid_b_reg;
    assign resp_id    = id_b_reg;
    assign resp_res   = res_b_reg;
    assign busy       = valid_a_reg || valid_b_reg;

endmodule

// File: tb/tb_fcvt_share_arbiter.sv
// Randomized and directed bench for fcvt_share_arbiter against a queue-based reference model.
module tb_fcvt_share_arbiter;
    localparam int NR = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [32*NR-1:0] req_op;
    logic [2*NR-1:0]  req_rmode;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_id;
    logic [31:0]      resp_res;
    logic             busy;
`ifdef FCVT_EXC_FLAGS_EN
    logic             resp_nv;
    logic             resp_nx;
`endif

    logic [31:0] ops [NR];
    logic [1:0]  rms [NR];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    for (genvar gi = 0; gi < NR; gi++) begin : g_pack
        assign req_op[32*gi +: 32]  = ops[gi];
        assign req_rmode[2*gi +: 2] = rms[gi];
    end

    fcvt_share_arbiter #(.NUM_REQ(NR), .ID_W(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rmode  (req_rmode),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_res   (resp_res),
`ifdef FCVT_EXC_FLAGS_EN
        .resp_nv    (resp_nv),
        .resp_nx    (resp_nx),
`endif
        .busy       (busy)
    );

    // Reference model: in-order queue of accepted requests, each aging one per clock.
    typedef struct {
        logic [1:0]  id;
        logic [31:0] res;
        logic        nv;
        logic        nx;
        int          age;
    } entry_t;

    entry_t        q[$];
    int            ptr_m     = 0;
    int            exp_grant = -1;
    logic [NR-1:0] exp_ready;
    logic          exp_rv;
    logic          exp_busy;

    task automatic ref_conv(input logic [31:0] op, input logic [1:0] rm,
                            output logic [31:0] res, output logic nv, output logic nx);
        int     e;
        int     sh;
        bit     s;
        bit     up;
        longint m;
        longint qi;
        longint r;
        longint den;
        longint mg;
        e   = int'(op[30:23]);
        s   = op[31];
        nv  = 1'b0;
        nx  = 1'b0;
        res = 32'd0;
        den = 0;
        up  = 1'b0;
        if (e >= 158) begin
            nv  = 1'b1;
            res = 32'h8000_0000;
            return;
        end
        if (op[30:0] == 31'd0) return;
        m  = (e == 0) ? longint'(op[22:0]) : longint'(op[22:0]) + (64'sd1 <<< 23);
        // value = m / 2^sh
        sh = (e == 0) ? 149 : 150 - e;
        if (sh <= 0) begin
            qi = m <<< (-sh);
            r  = 0;
        end else if (sh >= 62) begin
            qi = 0;
            r  = m;
        end else begin
            den = 64'sd1 <<< sh;
            qi  = m / den;
            r   = m % den;
        end
        nx = (r != 0);
        case (rm)
            2'd0:    up = (sh > 0) && (sh < 62) && ((2*r > den) || ((2*r == den) && (r != 0) && qi[0]));
            2'd1:    up = 1'b0;
            2'd2:    up = !s && (r != 0);
            default: up = s && (r != 0);
        endcase
        mg  = qi + (up ? 64'sd1 : 64'sd0);
        res = s ? 32'(-mg) : 32'(mg);
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        logic [7:0]  e;
        logic [22:0] f;
        f = 23'($urandom);
        case ($urandom_range(0, 11))
            0: v = {1'($urandom), 8'hFF, ($urandom_range(0, 1) == 0) ? 23'd0 : f};
            1: v = {1'($urandom), 8'h00, ($urandom_range(0, 1) == 0) ? 23'd0 : f};
            2: v = {1'($urandom), 8'($urandom_range(155, 159)), f};
            default: begin
                e = 8'($urandom_range(118, 152));
                if ($urandom_range(0, 2) == 0) f = f & 23'h7F0000;
                v = {1'($urandom), e, f};
            end
        endcase
        return v;
    endfunction

    task automatic model_expect();
        int idx;
        exp_grant = -1;
        exp_ready = '0;
        exp_rv    = (q.size() > 0) && (q[0].age >= 2);
        exp_busy  = (q.size() > 0);
        if (!reset && ((q.size() < 2) || resp_ready)) begin
            for (int k = 0; k < NR; k++) begin
                idx = (ptr_m + k) % NR;
                if (exp_grant < 0 && req_valid[idx]) exp_grant = idx;
            end
        end
        if (exp_grant >= 0) exp_ready[exp_grant] = 1'b1;
    endtask

    task automatic model_advance();
        entry_t ent;
        if (reset) begin
            q.delete();
            ptr_m = 0;
            return;
        end
        if (exp_rv && resp_ready) begin
            $display("resp t=%0t id=%0d res=%h", $time, q[0].id, q[0].res);
            void'(q.pop_front());
        end
        if (exp_grant >= 0) begin
            ref_conv(ops[exp_grant], rms[exp_grant], ent.res, ent.nv, ent.nx);
            ent.id  = 2'(exp_grant);
            ent.age = 0;
            q.push_back(ent);
            ptr_m = (exp_grant + 1) % NR;
        end
        for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        #1;
        model_expect();
        model_advance();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            ops[i] = rand_op();
            rms[i] = 2'(i);
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            #1;
            model_expect();
            total++;
            if (req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL reset_ready got=%b want=0000", req_ready);
            end
            model_advance();
            tick();
        end
        reset     = 1'b0;
        req_valid = '0;
        #1;
        model_expect();
        total++;
        if (resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_res !== 32'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got v=%b id=%0d res=%h busy=%b want all zero",
                     resp_valid, resp_id, resp_res, busy);
        end
`ifdef FCVT_EXC_FLAGS_EN
        total++;
        if (resp_nv !== 1'b0 || resp_nx !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got nv=%b nx=%b want 0 0", resp_nv, resp_nx);
        end
`endif
        model_advance();
        tick();
    endtask

    task automatic test_single(input int id, input logic [31:0] op, input logic [1:0] rm,
                               input logic [31:0] want, input logic want_nv, input logic want_nx);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        ops[id]       = op;
        rms[id]       = rm;
        resp_ready    = 1'b1;
        #1;
        model_expect();
        total++;
        if (req_ready !== (4'b0001 << id)) begin
            bad++;
            $display("FAIL single_ready id=%0d got=%b want=%b", id, req_ready, 4'b0001 << id);
        end
        model_advance();
        tick();
        req_valid = '0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            model_expect();
            total++;
            if (resp_valid !== (c == 2)) begin
                bad++;
                $display("FAIL single_latency cycle=%0d got=%b want=%b", c, resp_valid, (c == 2));
            end
            if (c == 2) begin
                total++;
                if (resp_id !== 2'(id) || resp_res !== want) begin
                    bad++;
                    $display("FAIL single_result op=%h rm=%0d got id=%0d res=%h want id=%0d res=%h",
                             op, rm, resp_id, resp_res, id, want);
                end
`ifdef FCVT_EXC_FLAGS_EN
                total++;
                if (resp_nv !== want_nv || resp_nx !== want_nx) begin
                    bad++;
                    $display("FAIL single_flags op=%h got nv=%b nx=%b want nv=%b nx=%b",
                             op, resp_nv, resp_nx, want_nv, want_nx);
                end
`endif
            end
            model_advance();
            tick();
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        req_valid  = '1;
        resp_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c == 12) req_valid = '0;
            if (exp_grant >= 0) begin
                ops[exp_grant] = rand_op();
                rms[exp_grant] = 2'($urandom_range(0, 3));
            end
            #1;
            model_expect();
            if (c < 12) begin
                total++;
                if (req_ready !== (4'b0001 << (c % NR))) begin
                    bad++;
                    $display("FAIL rr_grant cycle=%0d got=%b want=%b", c, req_ready, 4'b0001 << (c % NR));
                end
            end
            total++;
            if (resp_valid !== (c >= 2 && c < 14)) begin
                bad++;
                $display("FAIL rr_valid cycle=%0d got=%b want=%b", c, resp_valid, (c >= 2 && c < 14));
            end
            if (exp_rv) begin
                total++;
                if (resp_id !== 2'((c - 2) % NR) || resp_res !== q[0].res) begin
                    bad++;
                    $display("FAIL rr_result cycle=%0d got id=%0d res=%h want id=%0d res=%h",
                             c, resp_id, resp_res, (c - 2) % NR, q[0].res);
                end
            end
            model_advance();
            tick();
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 12; c++) begin
            req_valid  = (c < 7) ? 4'b1111 : 4'b0000;
            resp_ready = (c < 2 || c >= 7);
            if (exp_grant >= 0) begin
                ops[exp_grant] = rand_op();
                rms[exp_grant] = 2'($urandom_range(0, 3));
            end
            #1;
            model_expect();
            total++;
            if (req_ready !== exp_ready) begin
                bad++;
                $display("FAIL bp_ready cycle=%0d got=%b want=%b", c, req_ready, exp_ready);
            end
            if (c >= 2 && c < 7) begin
                total++;
                if (req_ready !== 4'b0000 || resp_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_stall cycle=%0d got ready=%b valid=%b want 0000 1",
                             c, req_ready, resp_valid);
                end
            end
            total++;
            if (resp_valid !== exp_rv || busy !== exp_busy) begin
                bad++;
                $display("FAIL bp_state cycle=%0d got v=%b busy=%b want v=%b busy=%b",
                         c, resp_valid, busy, exp_rv, exp_busy);
            end
            if (exp_rv) begin
                total++;
                if (resp_id !== q[0].id || resp_res !== q[0].res) begin
                    bad++;
                    $display("FAIL bp_result cycle=%0d got id=%0d res=%h want id=%0d res=%h",
                             c, resp_id, resp_res, q[0].id, q[0].res);
                end
            end
            if (c == 9) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_busy_drop got=%b want=0", busy);
                end
            end
            model_advance();
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 7; c++) begin
            reset      = (c == 2);
            req_valid  = (c < 4) ? 4'b1111 : 4'b0000;
            resp_ready = (c >= 3);
            #1;
            model_expect();
            if (c == 2) begin
                total++;
                if (req_ready !== 4'b0000 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL mid_reset_ready got ready=%b busy=%b want 0000 1", req_ready, busy);
                end
            end
            if (c == 3) begin
                total++;
                if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0001) begin
                    bad++;
                    $display("FAIL mid_reset_after got v=%b busy=%b ready=%b want 0 0 0001",
                             resp_valid, busy, req_ready);
                end
            end
            total++;
            if (resp_valid !== exp_rv || busy !== exp_busy) begin
                bad++;
                $display("FAIL mid_state cycle=%0d got v=%b busy=%b want v=%b busy=%b",
                         c, resp_valid, busy, exp_rv, exp_busy);
            end
            if (exp_rv) begin
                total++;
                if (resp_id !== q[0].id || resp_res !== q[0].res) begin
                    bad++;
                    $display("FAIL mid_result cycle=%0d got id=%0d res=%h want id=%0d res=%h",
                             c, resp_id, resp_res, q[0].id, q[0].res);
                end
            end
            model_advance();
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        test_single(3, 32'h4120_0000, 2'd0, 32'd10, 1'b0, 1'b0);
        test_single(1, 32'h0000_0000, 2'd2, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_random(input int cycles);
        req_valid = '0;
        for (int c = 0; c < cycles; c++) begin
            if (exp_grant >= 0) req_valid[exp_grant] = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 40) begin
                    req_valid[i] = 1'b1;
                    ops[i]       = rand_op();
                    rms[i]       = 2'($urandom_range(0, 3));
                end else if (req_valid[i] && $urandom_range(0, 99) < 2) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(0, 99) < 65);
            #1;
            model_expect();
            total++;
            if (req_ready !== exp_ready) begin
                bad++;
                $display("FAIL rnd_ready t=%0t got=%b want=%b", $time, req_ready, exp_ready);
            end
            total++;
            if (resp_valid !== exp_rv || busy !== exp_busy) begin
                bad++;
                $display("FAIL rnd_state t=%0t got v=%b busy=%b want v=%b busy=%b",
                         $time, resp_valid, busy, exp_rv, exp_busy);
            end
            if (exp_rv) begin
                total++;
                if (resp_id !== q[0].id || resp_res !== q[0].res) begin
                    bad++;
                    $display("FAIL rnd_result t=%0t got id=%0d res=%h want id=%0d res=%h",
                             $time, resp_id, resp_res, q[0].id, q[0].res);
                end
`ifdef FCVT_EXC_FLAGS_EN
                total++;
                if (resp_nv !== q[0].nv || resp_nx !== q[0].nx) begin
                    bad++;
                    $display("FAIL rnd_flags t=%0t got nv=%b nx=%b want nv=%b nx=%b",
                             $time, resp_nv, resp_nx, q[0].nv, q[0].nx);
                end
`endif
            end
            model_advance();
            tick();
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            ops[i] = 32'd0;
            rms[i] = 2'd0;
        end
        test_reset();
        test_single(0, 32'h3FC0_0000, 2'd0, 32'h0000_0002, 1'b0, 1'b1);
        test_single(0, 32'h3FC0_0000, 2'd1, 32'h0000_0001, 1'b0, 1'b1);
        test_single(2, 32'hC020_0000, 2'd1, 32'hFFFF_FFFE, 1'b0, 1'b1);
        test_single(2, 32'hC020_0000, 2'd3, 32'hFFFF_FFFD, 1'b0, 1'b1);
        test_single(2, 32'h7FC0_0000, 2'd0, 32'h8000_0000, 1'b1, 1'b0);
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_wrap();
        test_random(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
